// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes, data-memory
// freeze with timeout watchdog, and saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [15:0] wait_cnt;
    logic        load_use;
    logic        stall_evt;
    logic        flush_evt;

    // x0 is hardwired zero, so it never carries a dependency
    always_comb begin
        load_use = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_rs1_used && (id_rs1 == ex_rd)) ||
                    (id_rs2_used && (id_rs2 == ex_rd)));
    end

    // Next state and stage controls; reset and ERR both force a full bubble
    always_comb begin
        state_nxt   = state;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;

        if (rst) begin
            state_nxt   = S_RUN;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            case (state)
                S_RUN, S_WAIT: begin
                    if (mem_busy) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_flush = 1'b1;
                        stall_evt   = 1'b1;
                        if ((state == S_WAIT) && (wait_cnt == WAIT_LAST)) begin
                            state_nxt = S_ERR;
                        end else begin
                            state_nxt = S_WAIT;
                        end
                    end else begin
                        state_nxt = S_RUN;
                        if (br_taken) begin
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                            flush_evt  = 1'b1;
                        end else if (load_use) begin
                            pc_en      = 1'b0;
                            ifid_en    = 1'b0;
                            idex_flush = 1'b1;
                            stall_evt  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt   = S_ERR;
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    memwb_flush = 1'b1;
                end
            endcase
        end
    end

    // State, watchdog and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            wait_cnt  <= 16'd0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mem_err <= (state_nxt == S_ERR);
            if (!mem_busy) begin
                wait_cnt <= 16'd0;
            end else if (state != S_ERR) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (stall_evt && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: dut_a (TIMEOUT=4) covers control and watchdog,
// dut_b (CNT_W=2) shares the stimulus and covers counter saturation.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       br_taken;
    logic       mem_busy;

    logic        a_pc_en, a_ifid_en, a_idex_en, a_exmem_en;
    logic        a_ifid_flush, a_idex_flush, a_memwb_flush, a_mem_err;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_pc_en, b_ifid_en, b_idex_en, b_exmem_en;
    logic        b_ifid_flush, b_idex_flush, b_memwb_flush, b_mem_err;
    logic [1:0]  b_stall_cnt, b_flush_cnt;

    // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}
    localparam logic [6:0] C_RUN    = 7'b1111_000;
    localparam logic [6:0] C_BUBBLE = 7'b0000_111;
    localparam logic [6:0] C_FREEZE = 7'b0000_001;
    localparam logic [6:0] C_REDIR  = 7'b1111_110;
    localparam logic [6:0] C_STALL  = 7'b0011_010;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] stall;
        logic [31:0] flush;
        logic        chk_b;
        logic [31:0] stall_b;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec;
    int          n_bad;
    logic [31:0] e_stall, e_flush, e_stall_b;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_en(a_pc_en), .ifid_en(a_ifid_en), .idex_en(a_idex_en), .exmem_en(a_exmem_en),
        .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush), .memwb_flush(a_memwb_flush),
        .mem_err(a_mem_err), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    hazard_ctrl #(.TIMEOUT(255), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_en(b_pc_en), .ifid_en(b_ifid_en), .idex_en(b_idex_en), .exmem_en(b_exmem_en),
        .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush), .memwb_flush(b_memwb_flush),
        .mem_err(b_mem_err), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle at the falling edge, check controls, queue the post-edge state
    task automatic step(input string tag, input logic r,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic br, input logic busy,
                        input logic [6:0] ctl, input logic err_after, input logic chk_b);
        exp_t e;
        @(negedge clk);
        rst = r; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        ex_rd = rd; ex_mem_read = mr; br_taken = br; mem_busy = busy;
        if (r) begin
            e_stall = 0; e_flush = 0; e_stall_b = 0;
        end else if (ctl == C_FREEZE || ctl == C_STALL) begin
            e_stall = e_stall + 1;
            if (e_stall_b != 32'd3) e_stall_b = e_stall_b + 1;
        end else if (ctl == C_REDIR) begin
            e_flush = e_flush + 1;
        end
        e.tag = tag; e.err = err_after; e.stall = e_stall; e.flush = e_flush;
        e.chk_b = chk_b; e.stall_b = e_stall_b;
        sb_q.push_back(e);
        #2;
        check({tag, "/ctl"}, 32'({a_pc_en, a_ifid_en, a_idex_en, a_exmem_en,
                                  a_ifid_flush, a_idex_flush, a_memwb_flush}), 32'(ctl));
    endtask

    // Registered outputs are compared just after the edge that ends each driven cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check({e.tag, "/err"}, 32'(a_mem_err), 32'(e.err));
                check({e.tag, "/stall"}, 32'(a_stall_cnt), e.stall);
                check({e.tag, "/flush"}, 32'(a_flush_cnt), e.flush);
                if (e.chk_b) check({e.tag, "/stall_b"}, 32'(b_stall_cnt), e.stall_b);
            end
        end
    end

    initial begin
        n_vec = 0; n_bad = 0;
        e_stall = 0; e_flush = 0; e_stall_b = 0;
        rst = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;

        //    tag          rst rs1   rs2   u1 u2 rd    mr br bsy ctl       err  b
        step("reset",      1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_BUBBLE, 1'b0, 1'b1);
        step("idle",       0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_RUN,    1'b0, 1'b1);
        step("lu_rs2",     0, 5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, C_STALL,  1'b0, 1'b1);
        step("lu_x0",      0, 5'd0, 5'd0, 0, 1, 5'd0, 1, 0, 0, C_RUN,    1'b0, 1'b1);
        step("lu_unused",  0, 5'd0, 5'd5, 0, 0, 5'd5, 1, 0, 0, C_RUN,    1'b0, 1'b1);
        step("lu_rs1",     0, 5'd9, 5'd1, 1, 1, 5'd9, 1, 0, 0, C_STALL,  1'b0, 1'b1);
        step("no_load",    0, 5'd9, 5'd1, 1, 1, 5'd9, 0, 0, 0, C_RUN,    1'b0, 1'b1);
        step("reset2",     1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_BUBBLE, 1'b0, 1'b1);
        step("br_lu",      0, 5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 0, C_REDIR,  1'b0, 1'b1);

        // Busy for 3 cycles with a held branch: wait_cnt reaches TIMEOUT-1, no error
        for (int i = 0; i < 3; i++)
            step("frz_br",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, C_FREEZE, 1'b0, 1'b0);
        step("redir",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, C_REDIR,  1'b0, 1'b0);
        // A load-use under freeze is deferred, then counted again once busy drops
        step("frz_lu",     0, 5'd0, 5'd7, 0, 1, 5'd7, 1, 0, 1, C_FREEZE, 1'b0, 1'b0);
        step("lu_after",   0, 5'd0, 5'd7, 0, 1, 5'd7, 1, 0, 0, C_STALL,  1'b0, 1'b0);

        // Busy for TIMEOUT=4 cycles trips the watchdog at the 4th edge
        for (int i = 0; i < 3; i++)
            step("frz_to",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, C_FREEZE, 1'b0, 1'b0);
        step("frz_trip",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, C_FREEZE, 1'b1, 1'b0);
        step("err_idle",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_BUBBLE, 1'b1, 1'b0);
        step("err_br",     0, 5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 0, C_BUBBLE, 1'b1, 1'b0);
        step("err_busy",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, C_BUBBLE, 1'b1, 1'b0);
        step("reset3",     1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, C_BUBBLE, 1'b0, 1'b1);
        step("post_rst",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_RUN,    1'b0, 1'b1);

        // Five consecutive load-use stalls: dut_b saturates at 3
        for (int i = 0; i < 5; i++)
            step("sat",     0, 5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 0, C_STALL,  1'b0, 1'b1);
        step("sat_hold",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_RUN,    1'b0, 1'b1);

        @(posedge clk);
        #3;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It drives the `en` and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers (`DFF_reg` instances), deciding each cycle whether a stage captures, holds or takes a bubble. It resolves load-use hazards, taken-branch redirects and data-memory wait states. It also keeps a memory-timeout watchdog and two performance counters.

## Interface
Parameters:
- `TIMEOUT`, default 255: number of consecutive `mem_busy` cycles that trips `mem_err`. Legal range 2..2^16-1.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs1`  in  5  rs1 index of the instruction in ID.
- `id_rs2`  in  5  rs2 index of the instruction in ID.
- `id_rs1_used`  in  1  the ID instruction reads rs1.
- `id_rs2_used`  in  1  the ID instruction reads rs2.
- `ex_rd`  in  5  destination index of the instruction in EX.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `br_taken`  in  1  the EX branch/jump resolved taken.
- `mem_busy`  in  1  data memory is not ready this cycle.
- `pc_en`  out  1  PC register enable.
- `ifid_en`, `idex_en`, `exmem_en`  out  1 each  pipeline register enables.
- `ifid_flush`, `idex_flush`, `memwb_flush`  out  1 each  load a bubble (NOP, all-zero control) at the next edge.
- `mem_err`  out  1  sticky memory-timeout error.
- `stall_cnt`  out  CNT_W  count of stall cycles.
- `flush_cnt`  out  CNT_W  count of branch-flush cycles.

## Operation
Hazard terms:
- load_use = `ex_mem_read` && `ex_rd`!=0 && ((`id_rs1_used` && `id_rs1`==`ex_rd`) || (`id_rs2_used` && `id_rs2`==`ex_rd`)).
- Register x0 never creates a hazard.

Decode priority in states RUN/WAIT, highest first. Any output not listed takes its default; defaults are all enables 1, all flushes 0.
1. `mem_busy`=1, freeze:
   - `pc_en`=`ifid_en`=`idex_en`=`exmem_en`=0.
   - `memwb_flush`=1, so WB does not retire the same instruction twice.
2. `br_taken`=1, redirect:
   - `pc_en`=1 (PC loads the target).
   - `ifid_flush`=`idex_flush`=1.
   - Any load_use in the same cycle is ignored, because the ID instruction is killed.
3. load_use=1, stall:
   - `pc_en`=`ifid_en`=0.
   - `idex_flush`=1.
   - `exmem_en`=1.

FSM:
- RUN to WAIT when `mem_busy`=1.
- WAIT to RUN when `mem_busy`=0.
- WAIT to ERR at the edge that ends the TIMEOUT-th consecutive `mem_busy` cycle.
- ERR is absorbing; only `rst` exits it.

Wait counter:
- Internal counter `wait_cnt`, 16 bits.
- Cleared in any cycle with `mem_busy`=0.
- Incremented on each busy cycle.

ERR state:
- `mem_err`=1.
- All enables 0.
- All three flushes 1.
- Counters frozen.

Counters:
- Both saturate at 2^CNT_W-1 and never wrap.
- `stall_cnt` increments once per cycle in which rule 1 or rule 3 fires.
- `flush_cnt` increments once per cycle in which rule 2 fires.
- At most one of the two counters increments per cycle.

## Timing
- Enables and flushes are combinational from state and inputs, with zero latency. Register outputs change at the edge that ends the decision cycle.
- `mem_err`, `stall_cnt` and `flush_cnt` are registered. A counter reflects an event at the edge following it.
- While `rst`=1 the register outputs are overridden:
  - all enables 0;
  - all flushes 1.
- At the first edge with `rst`=1:
  - state becomes RUN;
  - `wait_cnt`, `stall_cnt` and `flush_cnt` become 0;
  - `mem_err` becomes 0.
- Reset applies in any state, including mid-WAIT and ERR. Normal decode resumes in the first cycle with `rst`=0.
- A load-use stall lasts exactly 1 cycle. After the edge, the load has moved to MEM and the ID/EX bubble clears the hazard.
- A load-use stall coincident with `mem_busy` is deferred: the freeze holds EX, so the hazard re-evaluates once busy drops. The stall is then counted again in that later cycle.
- `br_taken` stays asserted during a freeze because EX is held. The redirect fires in the first non-busy cycle.
- If `mem_busy` drops in the same cycle that `wait_cnt` equals TIMEOUT-1, the FSM goes to RUN with no error.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_rs2_used`=1 for 1 cycle. Required: `pc_en`=`ifid_en`=0, `idex_flush`=1 that cycle; `stall_cnt` goes 0 to 1.
- Same stimulus with `ex_rd`=0, or with `id_rs2_used`=0. Required: no stall; all enables 1; counters unchanged.
- `br_taken`=1 together with a load-use hazard. Required: `pc_en`=1, `ifid_flush`=`idex_flush`=1, `flush_cnt`=1, `stall_cnt`=0.
- `mem_busy` high for 3 cycles with `br_taken`=1 held. Required:
  - 3 freeze cycles with `memwb_flush`=1;
  - redirect in cycle 4;
  - final `stall_cnt`=3, `flush_cnt`=1.
- `TIMEOUT`=4:
  - `mem_busy` high for 4 cycles: `mem_err`=1 after the 4th edge; all enables stay 0 after busy drops.
  - `mem_busy` high for 3 cycles: no error.
  - Then assert `rst` for 1 cycle: `mem_err`=0, counters 0, state RUN.
- `CNT_W`=2 with 5 consecutive load-use stall cycles. Required: `stall_cnt` saturates at 3 and holds.
